// File: rtl/round_robin_arbiter_n.sv
// Round-robin arbiter for N requesters with registered one-hot grants and one-cycle latency.
// Define RR_ARB_BURST_LIMIT_EN to cap an owner's tenure at MAX_BURST cycles while others wait.
module round_robin_arbiter_n #(
    parameter  int N         = 4,
    parameter  int MAX_BURST = 4,
    localparam int IDW       = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   requests,
    output logic [N-1:0]   grants,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id
);

    if (N < 2 || MAX_BURST < 1) begin : g_bad_param
        $error("round_robin_arbiter_n: N must be >= 2 and MAX_BURST >= 1");
    end

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [N-1:0]   grants_nxt;
    logic           valid_nxt;
    logic [IDW-1:0] id_nxt;

    logic           scan_found;
    logic [IDW-1:0] scan_win;
    logic [IDW:0]   scan_idx;
    logic           owner_req;
    logic           hold;

    // Scan starts at ptr and wraps modulo N; IDW+1 bits holds ptr+k without overflow.
    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        scan_found = 1'b0;
        scan_win   = '0;
        scan_idx   = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = {1'b0, ptr} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(N)) begin
                scan_idx = scan_idx - (IDW+1)'(N);
            end
            if (!scan_found && requests[scan_idx[IDW-1:0]]) begin
                scan_found = 1'b1;
                scan_win   = scan_idx[IDW-1:0];
            end
        end
    end

    assign owner_req = grant_valid && requests[grant_id];

`ifdef RR_ARB_BURST_LIMIT_EN
    localparam int             CW      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_BURST - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          others_req;

    // An owner may overstay its burst only when nobody else is asking.
    assign others_req = |(requests & ~grants);
    assign hold       = owner_req && ((cnt < CNT_MAX) || !others_req);

    always_comb begin
        cnt_nxt = cnt;
        if (hold) begin
            cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        end else if (scan_found) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`else
    assign hold = owner_req;
`endif

    always_comb begin
        grants_nxt = grants;
        valid_nxt  = grant_valid;
        id_nxt     = grant_id;
        ptr_nxt    = ptr;
        if (!hold) begin
            if (scan_found) begin
                grants_nxt           = '0;
                grants_nxt[scan_win] = 1'b1;
                valid_nxt            = 1'b1;
                id_nxt               = scan_win;
                ptr_nxt              = (scan_win == IDW'(N - 1)) ? '0 : scan_win + IDW'(1);
            end else begin
                grants_nxt = '0;
                valid_nxt  = 1'b0;
                id_nxt     = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            grants      <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            ptr         <= '0;
        end else begin
            grants      <= grants_nxt;
            grant_valid <= valid_nxt;
            grant_id    <= id_nxt;
            ptr         <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_round_robin_arbiter_n.sv
// Bench for round_robin_arbiter_n (N=4, MAX_BURST=2): directed scenarios then random traffic
// against an owner/pointer/tenure reference model; follows RR_ARB_BURST_LIMIT_EN like the DUT.
module tb_round_robin_arbiter_n;

    localparam int N         = 4;
    localparam int MAX_BURST = 2;
    localparam int IDW       = 2;
`ifdef RR_ARB_BURST_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   requests = '0;
    logic [N-1:0]   grants;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: current owner (-1 = none), next scan start, cycles held so far.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_ten   = 0;

    round_robin_arbiter_n #(.N(N), .MAX_BURST(MAX_BURST)) dut (
        .clk         (clk),
        .rst         (rst),
        .requests    (requests),
        .grants      (grants),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic [N-1:0] req, input logic r);
        bit others;
        bit hold;
        int w;
        if (r) begin
            m_owner = -1;
            m_ptr   = 0;
            m_ten   = 0;
            return;
        end
        others = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (req[j] && j != m_owner) others = 1'b1;
        end
        hold = (m_owner >= 0) && req[m_owner] && (!LIMIT || m_ten < MAX_BURST || !others);
        if (hold) begin
            m_ten++;
        end else begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            if (w >= 0) begin
                m_owner = w;
                m_ptr   = (w + 1) % N;
                m_ten   = 1;
            end else begin
                m_owner = -1;
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model at the edge, compare just after it.
    task automatic step(input logic [N-1:0] req, input logic r, input string tag);
        logic [N-1:0] exp_g;
        @(negedge clk);
        requests = req;
        rst      = r;
        @(posedge clk);
        model_update(req, r);
        #1;
        exp_g = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        check({tag, ".grants"}, 32'(grants), 32'(exp_g));
        check({tag, ".valid"}, 32'(grant_valid), 32'(m_owner >= 0));
        check({tag, ".id"}, 32'(grant_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check({tag, ".onehot"}, 32'($countones(grants) <= 1), 32'd1);
    endtask

    initial begin
        logic [N-1:0] rq;

        // Reset, then idle.
        step(4'b0000, 1'b1, "reset");
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, "idle");

        // Everyone requesting: rotation with the burst limit, stuck owner without it.
        for (int i = 0; i < 10; i++) step(4'b1111, 1'b0, "all_req");
        step(4'b1110, 1'b0, "owner0_drop");
        step(4'b1110, 1'b0, "after_drop");

        // Sole persistent requester is never withdrawn.
        step(4'b0000, 1'b1, "reset2");
        for (int i = 0; i < 6; i++) step(4'b0100, 1'b0, "sole_req2");

        // Wrap-around: requester 3 wins (ptr -> 0), then contention between 0 and 3.
        step(4'b0000, 1'b1, "reset3");
        step(4'b1000, 1'b0, "win3");
        step(4'b0001, 1'b0, "wrap_owner_drop");
        step(4'b1001, 1'b0, "wrap_contend");
        step(4'b1000, 1'b0, "wrap_drop0");
        step(4'b1001, 1'b0, "wrap_rearb");

        // Reset in the middle of a requester-2 burst restarts the scan at 0.
        step(4'b0000, 1'b1, "reset4");
        step(4'b0100, 1'b0, "burst2_a");
        step(4'b1111, 1'b0, "burst2_b");
        step(4'b1111, 1'b1, "mid_burst_rst");
        step(4'b1111, 1'b0, "post_rst");
        step(4'b1111, 1'b0, "post_rst2");

        // Random traffic with sticky requests and rare resets.
        rq = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            step(rq, ($urandom_range(0, 59) == 0), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
